x_fwd_ctrl: RTL
===============

Name: x_fwd_ctrl

Overview:
- Parametrised execute-stage control unit for the RV32 pipeline.
- Replaces single-cycle X control: resolves branches and jumps, builds store byte enables and store data, drives ALU operand selects.
- Forwarding comes from an internal FWD_DEPTH-deep history of retired X instructions instead of externally supplied instruction words.
- Adds a multi-cycle flush counter and stall-aware history tracking. Sits between the D/X pipeline register and the ALU/branch-comparator/DMEM interface.

Parameters:
FWD_DEPTH, 2, number of older in-flight instructions tracked for forwarding (1..4)
FLUSH_CYCLES, 1, cycles flush stays asserted after a redirect (1..3)
FSEL_W, $clog2(FWD_DEPTH+1), width of forward-select outputs (derived, not overridable)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  X holds its instruction this cycle; no history or counter update
x_valid  in  1  x_inst is a live instruction
x_inst  in  32  instruction in X
br_eq  in  1  comparator equal
br_lt  in  1  comparator less-than (signedness per br_un)
addr_offset  in  2  ALU result [1:0] for stores
rs2_data  in  32  forwarded rs2 value
a_fwd_sel  out  FSEL_W  rs1 source: 0 regfile, k = history entry k
b_fwd_sel  out  FSEL_W  rs2 source, same encoding
a_sel  out  1  ALU A: 0 rs1 path, 1 PC
b_sel  out  1  ALU B: 0 rs2 path, 1 imm
br_un  out  1  unsigned compare
pc_sel  out  1  redirect PC to ALU result
branch_taken  out  1  conditional branch taken
flush  out  1  kill younger instructions
dmem_re  out  1  load read enable
mem_we  out  4  DMEM byte write enables
store_data  out  32  lane-aligned store data
load_use_stall  out  1  stall request (optional feature; 0 when compiled out)

Behaviour:
- Live instruction: live = x_valid && !flush_hold, where flush_hold = (flush_cnt != 0). A non-live instruction drives pc_sel = branch_taken = 0, mem_we = 0, dmem_re = 0.
- History: FWD_DEPTH entries of {valid, rd[4:0]}. Entry 1 is youngest.
  - On a cycle with !stall, shift entries down and load entry 1 with valid = live && writes_rd, where writes_rd = opcode not BRANCH or STORE, and rd != 0.
  - On stall, hold all entries.
- Forwarding:
  - rs1 is used by R, I, LOAD, STORE, BRANCH, JALR, and CSR with funct3 = RW.
  - rs2 is used by R, STORE, BRANCH.
  - fwd_sel = smallest k with entry k valid and rd == rs. Otherwise 0. Unused operand gives 0.
  - rs = x0 always gives 0.
- Operand selects:
  - a_sel = 1 for BRANCH, JAL, AUIPC; else 0.
  - b_sel = 0 for R only; else 1.
- Branch resolution:
  - br_un = 1 for BLTU/BGEU.
  - Taken per BEQ/BNE/BLT/BGE/BLTU/BGEU; undefined funct3 is not taken.
  - pc_sel = taken || JAL || JALR (live only).
- Flush:
  - flush = (live && pc_sel) || flush_hold.
  - On a cycle with !stall and live && pc_sel, flush_cnt loads FLUSH_CYCLES-1. Otherwise, on !stall, it decrements when non-zero.
  - Stall freezes flush_cnt.
- Stores:
  - SB: mem_we = 1 << addr_offset; byte replicated into the selected lane, zero elsewhere.
  - SH: addr_offset[1] selects 0011/1100, data shifted by 16.
  - SW: 1111.
  - Misaligned SH (addr_offset[0] = 1) or SW (addr_offset != 0): mem_we = 0.
  - store_data = rs2_data for all non-store instructions.
- dmem_re = live && LOAD.
- All outputs are combinational from x_inst, inputs, history, and flush_cnt.
- Reset: history invalid, flush_cnt = 0, all outputs 0 while reset_n = 0. Reset mid-flush aborts the flush. The first live instruction after reset sees no forwarding.

Optional Feature:
X_LOAD_USE_STALL_EN:
- Defined: history entries carry an is_load bit. If entry 1 is a load that matches a used rs, load_use_stall = 1 for one cycle.
- During that cycle the instruction is treated as non-live: a bubble is pushed into history, and pc_sel and mem_we are 0.
- On the next cycle entry 2 matches and the instruction proceeds normally. External logic must assert stall in response.
- Undefined: is_load is not stored and load_use_stall is tied to 0.

Decomposition:
- Package x_ctrl_pkg holds:
  - opcode and funct3 constants (existing defines re-exported)
  - forward-select encoding (FWD_RF = 0)
  - history entry struct {valid, is_load, rd}
  - a uses_rs1/uses_rs2/writes_rd decode function
- Sub-module x_fwd_history: shift register plus priority match, FWD_DEPTH-generic, producing both fwd selects.

Test Plan:
- FWD_DEPTH=2: addi x5; add x6,x5,x5 -> a_fwd_sel=b_fwd_sel=1; a following sub x7,x5,x0 -> a_fwd_sel=2, b_fwd_sel=0.
- Same rd in entries 1 and 2, rs1 = that rd -> a_fwd_sel=1. Repeat with stall=1 for 3 cycles -> selects unchanged, history unchanged.
- beq with br_eq=1, FLUSH_CYCLES=2 -> pc_sel=1, branch_taken=1, flush high 2 cycles. The next instruction (jal) during the flush -> pc_sel=0, not pushed into history.
- sb with addr_offset=2, rs2_data=0x123456AB -> mem_we=0100, store_data=0x00AB0000. sh with offset 3 -> mem_we=0000.
- bltu with br_lt=1 -> br_un=1, taken. bge with br_lt=1 -> not taken, flush=0.
- reset_n low during flush_cnt=1 -> flush drops immediately, history cleared. The first instruction after release -> fwd selects 0.

Source files
------------

// File: rtl/x_ctrl_pkg.sv
// x_ctrl_pkg: shared opcode/funct3 constants, forwarding history entry type
// and the register-usage decode used by the execute-stage control unit.
package x_ctrl_pkg;

  // RV32 major opcodes used by X-stage control
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Store funct3
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // CSR read/write variant is the only CSR form that reads rs1 here
  localparam logic [2:0] F3_CSRRW = 3'b001;

  // Forward-select value meaning "take the register file"
  localparam int FWD_RF = 0;

  // One retired X instruction as remembered for forwarding
  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [4:0] rd;
  } hist_entry_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } rs_use_t;

  // Which source registers an instruction reads and whether it writes rd
  function automatic rs_use_t decode_rs_use(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [4:0] rd);
    rs_use_t u;
    u.uses_rs1  = (opcode == OP_REG)   || (opcode == OP_IMM)    ||
                  (opcode == OP_LOAD)  || (opcode == OP_STORE)  ||
                  (opcode == OP_BRANCH) || (opcode == OP_JALR)  ||
                  ((opcode == OP_SYSTEM) && (funct3 == F3_CSRRW));
    u.uses_rs2  = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    u.writes_rd = (opcode != OP_BRANCH) && (opcode != OP_STORE) && (rd != 5'd0);
    return u;
  endfunction

endpackage

// File: rtl/x_fwd_history.sv
// x_fwd_history: shift register of the last FWD_DEPTH retired X instructions
// with a youngest-first priority match producing the rs1/rs2 forward selects.
module x_fwd_history
  import x_ctrl_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int FSEL_W    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  hist_entry_t       push,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  output logic [FSEL_W-1:0] a_fwd_sel,
  output logic [FSEL_W-1:0] b_fwd_sel,
  output hist_entry_t       youngest
);

  // Entry 1 is the youngest retired instruction
  hist_entry_t hist [1:FWD_DEPTH];

  // Shift in the instruction leaving X; a stalled X leaves the history untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= FWD_DEPTH; k++) hist[k] <= '0;
    end else if (!stall) begin
      hist[1] <= push;
      for (int k = 2; k <= FWD_DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  // Scanning oldest to youngest lets the youngest matching producer win
  always_comb begin
    a_fwd_sel = FSEL_W'(FWD_RF);
    b_fwd_sel = FSEL_W'(FWD_RF);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (use_rs1 && (rs1 != 5'd0) && hist[k].valid && (hist[k].rd == rs1))
        a_fwd_sel = FSEL_W'(k);
      if (use_rs2 && (rs2 != 5'd0) && hist[k].valid && (hist[k].rd == rs2))
        b_fwd_sel = FSEL_W'(k);
    end
  end

  assign youngest = hist[1];

endmodule

// File: rtl/x_fwd_ctrl.sv
// x_fwd_ctrl: RV32 execute-stage control. Resolves branches/jumps, drives the
// multi-cycle flush, builds store lanes/enables, selects ALU operands and
// derives forward selects from an internal history of retired X instructions.
// Optional build macro X_LOAD_USE_STALL_EN adds load-use detection; without it
// load_use_stall is tied low.
module x_fwd_ctrl
  import x_ctrl_pkg::*;
#(
  parameter  int FWD_DEPTH    = 2,
  parameter  int FLUSH_CYCLES = 1,
  localparam int FSEL_W       = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              x_valid,
  input  logic [31:0]       x_inst,
  input  logic              br_eq,
  input  logic              br_lt,
  input  logic [1:0]        addr_offset,
  input  logic [31:0]       rs2_data,
  output logic [FSEL_W-1:0] a_fwd_sel,
  output logic [FSEL_W-1:0] b_fwd_sel,
  output logic              a_sel,
  output logic              b_sel,
  output logic              br_un,
  output logic              pc_sel,
  output logic              branch_taken,
  output logic              flush,
  output logic              dmem_re,
  output logic [3:0]        mem_we,
  output logic [31:0]       store_data,
  output logic              load_use_stall
);

  // Wide enough for FLUSH_CYCLES-1 up to 2
  localparam int CNT_W = 2;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  rs_use_t           rs_use;
  logic [CNT_W-1:0]  flush_cnt;
  logic              flush_hold;
  logic              lu_hit;
  logic              live;
  logic              cond;
  logic              taken;
  logic              redirect;
  hist_entry_t       push;
  hist_entry_t       youngest;
  logic [FSEL_W-1:0] a_fwd_raw;
  logic [FSEL_W-1:0] b_fwd_raw;
  logic [3:0]        mem_we_raw;
  logic [31:0]       store_data_raw;
  logic              unused_inst;

  assign opcode = x_inst[6:0];
  assign rd     = x_inst[11:7];
  assign funct3 = x_inst[14:12];
  assign rs1    = x_inst[19:15];
  assign rs2    = x_inst[24:20];

  // funct7/upper immediate bits carry no control meaning in X
  assign unused_inst = ^x_inst[31:25];

  assign rs_use     = decode_rs_use(opcode, funct3, rd);
  assign flush_hold = (flush_cnt != '0);

`ifdef X_LOAD_USE_STALL_EN
  // A consumer of the load sitting in entry 1 is turned into a bubble for one cycle
  assign lu_hit = x_valid && !flush_hold && youngest.is_load &&
                  ((a_fwd_raw == FSEL_W'(1)) || (b_fwd_raw == FSEL_W'(1)));
`else
  logic unused_youngest;
  assign unused_youngest = ^youngest;
  assign lu_hit          = 1'b0;
`endif

  assign live = x_valid && !flush_hold && !lu_hit;

  // Branch condition from the comparator flags; undefined funct3 never takes
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = br_eq;
      F3_BNE:  cond = !br_eq;
      F3_BLT:  cond = br_lt;
      F3_BGE:  cond = !br_lt;
      F3_BLTU: cond = br_lt;
      F3_BGEU: cond = !br_lt;
      default: cond = 1'b0;
    endcase
  end

  assign taken    = live && (opcode == OP_BRANCH) && cond;
  assign redirect = taken || (live && ((opcode == OP_JAL) || (opcode == OP_JALR)));

  // Entry pushed into the history when X advances; non-live slots become bubbles
  always_comb begin
    push       = '0;
    push.valid = live && rs_use.writes_rd;
    push.rd    = rd;
`ifdef X_LOAD_USE_STALL_EN
    push.is_load = (opcode == OP_LOAD);
`endif
  end

  x_fwd_history #(
    .FWD_DEPTH (FWD_DEPTH),
    .FSEL_W    (FSEL_W)
  ) u_hist (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .push      (push),
    .rs1       (rs1),
    .rs2       (rs2),
    .use_rs1   (rs_use.uses_rs1),
    .use_rs2   (rs_use.uses_rs2),
    .a_fwd_sel (a_fwd_raw),
    .b_fwd_sel (b_fwd_raw),
    .youngest  (youngest)
  );

  // Flush countdown: a redirect arms the extra flush cycles, stall freezes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt <= '0;
    end else if (!stall) begin
      if (redirect)
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
      else if (flush_hold)
        flush_cnt <= flush_cnt - CNT_W'(1);
    end
  end

  // Store lane placement; misaligned SH/SW suppress the write but SH data
  // still follows addr_offset[1]
  always_comb begin
    mem_we_raw     = 4'b0000;
    store_data_raw = rs2_data;
    if (opcode == OP_STORE) begin
      case (funct3)
        F3_SB: begin
          mem_we_raw     = 4'b0001 << addr_offset;
          store_data_raw = {24'h0, rs2_data[7:0]} << {addr_offset, 3'b000};
        end
        F3_SH: begin
          mem_we_raw     = addr_offset[0] ? 4'b0000 :
                           (addr_offset[1] ? 4'b1100 : 4'b0011);
          store_data_raw = addr_offset[1] ? {rs2_data[15:0], 16'h0} :
                                            {16'h0, rs2_data[15:0]};
        end
        F3_SW: begin
          mem_we_raw = (addr_offset == 2'b00) ? 4'b1111 : 4'b0000;
        end
        default: ;
      endcase
    end
  end

  // Output drive; everything reads as zero while reset is held
  always_comb begin
    a_fwd_sel      = '0;
    b_fwd_sel      = '0;
    a_sel          = 1'b0;
    b_sel          = 1'b0;
    br_un          = 1'b0;
    pc_sel         = 1'b0;
    branch_taken   = 1'b0;
    flush          = 1'b0;
    dmem_re        = 1'b0;
    mem_we         = 4'b0000;
    store_data     = '0;
    load_use_stall = 1'b0;
    if (reset_n) begin
      a_fwd_sel      = a_fwd_raw;
      b_fwd_sel      = b_fwd_raw;
      a_sel          = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_AUIPC);
      b_sel          = (opcode != OP_REG);
      br_un          = (opcode == OP_BRANCH) && ((funct3 == F3_BLTU) || (funct3 == F3_BGEU));
      pc_sel         = redirect;
      branch_taken   = taken;
      flush          = redirect || flush_hold;
      dmem_re        = live && (opcode == OP_LOAD);
      mem_we         = live ? mem_we_raw : 4'b0000;
      store_data     = store_data_raw;
      load_use_stall = lu_hit;
    end
  end

endmodule
